// File: rtl/imm12_narrow.sv
// rtl/imm12_narrow.sv - narrows a 64-bit operand into an imm12 field (optional LSL #12) behind a 2-entry skid buffer
module imm12_narrow #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_imm,
    output logic              out_sh,
    output logic              out_fits,
    output logic [CNT_W-1:0]  reject_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // entry layout: {fits, sh, imm[11:0]}
    logic [1:0]       state_q, state_d;
    logic [13:0]      main_q, main_d;
    logic [13:0]      skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] reject_q, reject_d;

    logic [11:0] enc_imm;
    logic        enc_sh;
    logic        enc_fits;
    logic [13:0] enc_entry;
    logic        in_xfer;
    logic        out_xfer;

    always_comb begin
        enc_imm  = in_data[11:0];
        enc_sh   = 1'b0;
        enc_fits = 1'b0;
        if (in_data[DATA_W-1:12] == '0) begin
            enc_fits = 1'b1;
        end else if (in_data[DATA_W-1:24] == '0 && in_data[11:0] == 12'd0) begin
            enc_imm  = in_data[23:12];
            enc_sh   = 1'b1;
            enc_fits = 1'b1;
        end
    end

    assign enc_entry = {enc_fits, enc_sh, enc_imm};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = enc_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = enc_entry;
                end else if (in_xfer) begin
                    skid_d  = enc_entry;
                    state_d = ST_TWO;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // in_ready comes from the next state so it never depends on out_ready combinationally
    assign in_ready_d = (state_d != ST_TWO);

    always_comb begin
        reject_d = reject_q;
        if (out_xfer && !main_q[13] && reject_q != '1) begin
            reject_d = reject_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            reject_q   <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            reject_q   <= reject_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_imm    = main_q[11:0];
    assign out_sh     = main_q[12];
    assign out_fits   = main_q[13];
    assign reject_cnt = reject_q;

endmodule

// File: doc/imm12_narrow.md
IMM12_NARROW -- requirements
Module: imm12_narrow

Interface
REQ-001 Parameter: DATA_W, 64, width of the input operand; only 64 is supported.
REQ-002 Parameter: CNT_W, 16, width of the reject counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  input operand valid.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 in_data  input  DATA_W  64-bit value to narrow into an imm12 field.
REQ-008 out_valid  output  1  encoded result valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 out_imm  output  12  encoded immediate field.
REQ-011 out_sh  output  1  1 = field is applied with LSL #12; 0 = unshifted.
REQ-012 out_fits  output  1  1 = in_data is exactly representable; 0 = not representable.
REQ-013 reject_cnt  output  CNT_W  count of delivered results with out_fits=0.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready at a rising edge; an output transfer SHALL occur when out_valid && out_ready at a rising edge.
REQ-015 If in_data[63:12]==0, the encoding SHALL be out_imm=in_data[11:0], out_sh=0, out_fits=1; this case includes zero.
REQ-016 Else if in_data[63:24]==0 and in_data[11:0]==0, the encoding SHALL be out_imm=in_data[23:12], out_sh=1, out_fits=1.
REQ-017 Otherwise the encoding SHALL be out_imm=in_data[11:0], out_sh=0, out_fits=0.
REQ-018 Encoding SHALL be computed combinationally before registering; no input bit above bit 63 exists, and no truncation warning path exists.
REQ-019 Buffering SHALL be a 2-entry skid structure: a main register driving the outputs plus one skid register.
REQ-020 The FSM SHALL have three states: EMPTY (0 entries), ONE (main full), TWO (main and skid full).
REQ-021 EMPTY -> ONE on an input transfer.
REQ-022 ONE -> ONE on a simultaneous input and output transfer, with main reloaded from the input; ONE -> EMPTY on an output transfer only; ONE -> TWO on an input transfer only, with the input captured in skid.
REQ-023 TWO -> ONE on an output transfer, with main loaded from skid; no input transfer is possible in TWO.
REQ-024 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, registered from state, with no combinational path from out_ready.
REQ-025 out_valid SHALL be 1 in ONE and TWO.
REQ-026 Latency: an operand accepted at edge N SHALL appear on the outputs from edge N+1 if the buffer was empty.
REQ-027 Throughput SHALL be one result per cycle when out_ready is held at 1.
REQ-028 Results SHALL be delivered in acceptance order, with no loss or duplication.
REQ-029 While out_valid && !out_ready, out_imm, out_sh and out_fits SHALL hold stable.
REQ-030 reject_cnt SHALL increment by 1 on each output transfer with out_fits=0.
REQ-031 reject_cnt SHALL saturate at all-ones and never wrap.
REQ-032 Output transfers with out_fits=1 SHALL leave reject_cnt unchanged.

Reset
REQ-033 reset_n=0 SHALL immediately, without waiting for clk, force: state=EMPTY, in_ready=0, out_valid=0, out_imm=0, out_sh=0, out_fits=0, reject_cnt=0.
REQ-034 in_ready SHALL rise at the first rising edge after reset_n deasserts.
REQ-035 Reset asserted mid-operation SHALL discard both buffered entries, and no partial output SHALL appear after release.

Verification
REQ-036 Send 0x0000_0000_0000_0ABC with out_ready=1 -> one cycle later out_imm=0xABC, out_sh=0, out_fits=1, reject_cnt=0.
REQ-037 Send 0x0000_0000_0012_3000 -> out_imm=0x123, out_sh=1, out_fits=1; send 0x0000_0000_0012_3001 -> out_imm=0x001, out_sh=0, out_fits=0, reject_cnt=1.
REQ-038 With out_ready=0, send A=0x5 then B=0x6 -> in_ready=0 after B; outputs hold 0x005; raise out_ready -> 0x005 then 0x006 on consecutive cycles, and in_ready returns to 1.
REQ-039 Streaming with out_ready=1 and 100 back-to-back random operands -> 100 results, in order, matching the REQ-015..017 model, one per cycle.
REQ-040 Preload reject_cnt to all-ones via 65535 non-fitting values, then send 0xFFFF_FFFF_FFFF_FFFF -> reject_cnt stays 0xFFFF.
REQ-041 Fill to TWO, then pulse reset_n low mid-cycle -> out_valid=0 and reject_cnt=0 immediately; after release, no stale results appear.
